// File: rtl/uart_tx_unit_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_tx_unit_if : request/line signal bundle of the UART transmitter
// Revision 1.0
// ---------------------------------------------------------------------------
interface uart_tx_unit_if;
   logic       send;
   logic [7:0] data_in;
   logic [1:0] parity_type;
   logic [1:0] baud_rate;
   logic       data_tx;
   logic       busy;
   logic       done;

   modport master (
      output send, data_in, parity_type, baud_rate,
      input  data_tx, busy, done
   );

   modport slave (
      input  send, data_in, parity_type, baud_rate,
      output data_tx, busy, done
   );
endinterface
`default_nettype wire

// File: rtl/uart_tx_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_tx_unit : 8-bit UART transmitter, optional odd/even parity, 4 baud rates
// Revision 1.0
// ---------------------------------------------------------------------------
module uart_tx_unit #(
   parameter int CLK_FREQ = 50_000_000
) (
   input  logic          clock,
   input  logic          reset_n,
   uart_tx_unit_if.slave bus
);

   localparam logic [14:0] DIV_2400  = 15'((CLK_FREQ + 1200) / 2400);
   localparam logic [14:0] DIV_4800  = 15'((CLK_FREQ + 2400) / 4800);
   localparam logic [14:0] DIV_9600  = 15'((CLK_FREQ + 4800) / 9600);
   localparam logic [14:0] DIV_19200 = 15'((CLK_FREQ + 9600) / 19200);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t      r_state;
   logic        r_tx;
   logic        r_busy;
   logic        r_done;
   logic [7:0]  r_data;
   logic [1:0]  r_par;
   logic [14:0] r_div;
   logic [14:0] r_cnt;
   logic [2:0]  r_bit;

   logic [14:0] w_div;
   logic        w_bit_end;
   logic        w_par_en;
   logic        w_par_bit;

   always_comb begin
      w_div = DIV_2400;
      case (bus.baud_rate)
         2'b00:   w_div = DIV_2400;
         2'b01:   w_div = DIV_4800;
         2'b10:   w_div = DIV_9600;
         default: w_div = DIV_19200;
      endcase
   end

   // Counter runs 0..N-1 and reloads at every bit boundary, so bits never drift
   assign w_bit_end = (r_cnt == (r_div - 15'd1));
   assign w_par_en  = (r_par == 2'b01) || (r_par == 2'b10);
   assign w_par_bit = (r_par == 2'b01) ? ~^r_data : ^r_data;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_tx    <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_data  <= 8'd0;
         r_par   <= 2'd0;
         r_div   <= 15'd0;
         r_cnt   <= 15'd0;
         r_bit   <= 3'd0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               r_tx   <= 1'b1;
               r_busy <= 1'b0;
               if (bus.send) begin
                  r_data  <= bus.data_in;
                  r_par   <= bus.parity_type;
                  r_div   <= w_div;
                  r_cnt   <= 15'd0;
                  r_bit   <= 3'd0;
                  r_tx    <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= START;
               end
            end
            START: begin
               if (w_bit_end) begin
                  r_cnt   <= 15'd0;
                  r_bit   <= 3'd0;
                  r_tx    <= r_data[0];
                  r_state <= DATA;
               end else begin
                  r_cnt <= r_cnt + 15'd1;
               end
            end
            DATA: begin
               if (w_bit_end) begin
                  r_cnt <= 15'd0;
                  if (r_bit == 3'd7) begin
                     if (w_par_en) begin
                        r_tx    <= w_par_bit;
                        r_state <= PARITY;
                     end else begin
                        r_tx    <= 1'b1;
                        r_state <= STOP;
                     end
                  end else begin
                     r_bit <= r_bit + 3'd1;
                     r_tx  <= r_data[r_bit + 3'd1];
                  end
               end else begin
                  r_cnt <= r_cnt + 15'd1;
               end
            end
            PARITY: begin
               if (w_bit_end) begin
                  r_cnt   <= 15'd0;
                  r_tx    <= 1'b1;
                  r_state <= STOP;
               end else begin
                  r_cnt <= r_cnt + 15'd1;
               end
            end
            STOP: begin
               if (w_bit_end) begin
                  r_cnt   <= 15'd0;
                  r_tx    <= 1'b1;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= IDLE;
               end else begin
                  r_cnt <= r_cnt + 15'd1;
               end
            end
            default: begin
               r_tx    <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.data_tx = r_tx;
   assign bus.busy    = r_busy;
   assign bus.done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_uart_tx_unit : randomized self-checking bench against a frame-level model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_uart_tx_unit;

   // Scaled clock keeps frames short: divisors become 80/40/20/10
   localparam int CLK_FREQ = 192_000;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   uart_tx_unit_if bus ();

   uart_tx_unit #(.CLK_FREQ(CLK_FREQ)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input int observed, input int expected);
      checks++;
      if (observed != expected) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, observed, expected);
      end
   endtask

   function automatic int model_div(input logic [1:0] b);
      int baud;
      baud = 2400 << b;
      return (CLK_FREQ + baud / 2) / baud;
   endfunction

   function automatic int model_len(input logic [1:0] p);
      return (p == 2'b01 || p == 2'b10) ? 11 : 10;
   endfunction

   // Frame bit idx: 0 = start, 1..8 = data LSB first, optional parity, then stop
   function automatic int model_bit(input logic [7:0] d, input logic [1:0] p, input int idx);
      int ones;
      ones = $countones(d);
      if (idx == 0) return 0;
      if (idx <= 8) return (int'(d) >> (idx - 1)) % 2;
      if (idx == 9 && model_len(p) == 11) begin
         if (p == 2'b01) return (ones % 2 == 0) ? 1 : 0;
         return ones % 2;
      end
      return 1;
   endfunction

   // Called at a negedge; send is accepted at the following posedge
   task automatic send_frame(input logic [7:0] d, input logic [1:0] p, input logic [1:0] b,
                             input bit hold, input bit disturb, input string tag);
      int n, f, busy_cnt, done_cnt;
      int good [11];
      n = model_div(b);
      f = model_len(p);
      busy_cnt = 0;
      done_cnt = 0;
      foreach (good[i]) good[i] = 0;
      bus.send        = 1'b1;
      bus.data_in     = d;
      bus.parity_type = p;
      bus.baud_rate   = b;
      @(negedge clock);
      if (!hold) bus.send = 1'b0;
      for (int t = 0; t < f * n; t++) begin
         if (int'(bus.data_tx) == model_bit(d, p, t / n)) good[t / n]++;
         busy_cnt += int'(bus.busy);
         done_cnt += int'(bus.done);
         if (disturb && t == 3 * n + 1) begin
            bus.send        = 1'b1;
            bus.data_in     = 8'h00;
            bus.baud_rate   = b + 2'd1;
            bus.parity_type = p ^ 2'b11;
         end else if (disturb && t == 3 * n + 2) begin
            bus.send = 1'b0;
         end
         @(negedge clock);
      end
      for (int i = 0; i < f; i++) check($sformatf("%s_bit%0d", tag, i), good[i], n);
      check({tag, "_busy_len"}, busy_cnt, f * n);
      check({tag, "_done_early"}, done_cnt, 0);
      check({tag, "_end_busy"}, int'(bus.busy), 0);
      check({tag, "_end_done"}, int'(bus.done), 1);
      check({tag, "_end_tx"}, int'(bus.data_tx), 1);
   endtask

   task automatic idle_cycles(input int k, input string tag);
      int busy_cnt, low_cnt;
      busy_cnt = 0;
      low_cnt  = 0;
      for (int i = 0; i < k; i++) begin
         @(negedge clock);
         busy_cnt += int'(bus.busy);
         low_cnt  += int'(!bus.data_tx);
      end
      check({tag, "_idle_busy"}, busy_cnt, 0);
      check({tag, "_idle_tx_low"}, low_cnt, 0);
   endtask

   initial begin
      int done_seen;
      bus.send        = 1'b0;
      bus.data_in     = 8'h00;
      bus.parity_type = 2'b00;
      bus.baud_rate   = 2'b00;

      repeat (3) @(negedge clock);
      check("rst_tx", int'(bus.data_tx), 1);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_done", int'(bus.done), 0);
      reset_n = 1'b1;
      idle_cycles(2, "post_rst");

      send_frame(8'h2B, 2'b01, 2'b10, 1'b0, 1'b0, "odd9600");
      idle_cycles(3, "odd9600");
      send_frame(8'h2B, 2'b10, 2'b11, 1'b0, 1'b0, "even19200");
      idle_cycles(3, "even19200");
      send_frame(8'hFF, 2'b00, 2'b00, 1'b0, 1'b0, "none2400");
      idle_cycles(3, "none2400");

      send_frame(8'hC6, 2'b10, 2'b01, 1'b0, 1'b1, "busy_rej");
      idle_cycles(5, "busy_rej");

      // Back-to-back: the done cycle is the single idle-high clock between frames
      for (int i = 0; i < 3; i++) send_frame(8'h55, 2'b00, 2'b11, 1'b1, 1'b0, $sformatf("b2b%0d", i));
      bus.send = 1'b0;
      idle_cycles(3, "b2b");

      // Reset during data bit 3 (frame bit index 4)
      bus.send        = 1'b1;
      bus.data_in     = 8'hA5;
      bus.parity_type = 2'b01;
      bus.baud_rate   = 2'b11;
      @(negedge clock);
      bus.send = 1'b0;
      repeat (4 * model_div(2'b11) + 5) @(negedge clock);
      check("mid_busy_before_rst", int'(bus.busy), 1);
      #2 reset_n = 1'b0;
      #1;
      check("mid_rst_tx", int'(bus.data_tx), 1);
      check("mid_rst_busy", int'(bus.busy), 0);
      check("mid_rst_done", int'(bus.done), 0);
      done_seen = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         done_seen += int'(bus.done);
      end
      reset_n = 1'b1;
      for (int i = 0; i < 3 * model_len(2'b01) * model_div(2'b11); i++) begin
         @(negedge clock);
         done_seen += int'(bus.done);
      end
      check("mid_rst_no_done", done_seen, 0);
      check("mid_rst_idle_busy", int'(bus.busy), 0);
      send_frame(8'hA5, 2'b01, 2'b11, 1'b0, 1'b0, "after_rst");
      idle_cycles(2, "after_rst");

      for (int r = 0; r < 6; r++) begin
         logic [7:0] d;
         logic [1:0] p, b;
         d = 8'($urandom);
         p = 2'($urandom_range(0, 3));
         b = 2'($urandom_range(0, 3));
         send_frame(d, p, b, 1'b0, 1'b0, $sformatf("rand%0d", r));
         idle_cycles(int'($urandom_range(1, 4)), $sformatf("rand%0d", r));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
